ct_down_timer: RTL

- Loadable down-counting interval timer.
- Counterpart to the up-counting load/enable counter bit slices: it counts a CPU-written reload value down to zero, raises a terminal-count pulse and a sticky interrupt, and then either reloads (periodic mode) or halts (one-shot mode).
- Sits between the 8-bit CPU register write strobes and the interrupt logic.
- A single clock domain with the CK/RESETL convention.

---
 rtl/ct_down_timer.sv | 80 ++++++++
 1 files changed

// File: rtl/ct_down_timer.sv
// Loadable down-counting interval timer: counts a CPU-written reload value to zero,
// pulses TC, sets a sticky IRQ, then reloads (periodic) or halts (one-shot).
module ct_down_timer #(
    parameter int WIDTH = 16
) (
    input  logic             CK,
    input  logic             RESETL,
    input  logic [7:0]       DIN,
    input  logic             LDLO,
    input  logic             LDHI,
    input  logic             START,
    input  logic             STOP,
    input  logic             MODE,
    input  logic             ENAB,
    input  logic             IACK,
    output logic [WIDTH-1:0] Q,
    output logic             TC,
    output logic             IRQ,
    output logic             RUN
);

    logic [WIDTH-1:0] reload;
    logic [WIDTH-1:0] reload_nxt;
    logic [WIDTH-1:0] count;
    logic             run_r;
    logic             tc_r;
    logic             irq_r;
    logic             count_en;
    logic             terminal;

    // START must see bytes written on the same edge, so it loads from the merged value.
    always_comb begin
        reload_nxt = reload;
        if (LDLO) reload_nxt[7:0] = DIN;
        if (LDHI) reload_nxt[WIDTH-1:8] = DIN[WIDTH-9:0];
    end

    assign count_en = run_r && ENAB && !STOP && !START;
    assign terminal = count_en && (count == '0);

    always_ff @(posedge CK or negedge RESETL) begin
        if (!RESETL) begin
            reload <= '0;
            count  <= '0;
            run_r  <= 1'b0;
            tc_r   <= 1'b0;
            irq_r  <= 1'b0;
        end else begin
            reload <= reload_nxt;
            tc_r   <= terminal;
            if (terminal)
                irq_r <= 1'b1;
            else if (IACK)
                irq_r <= 1'b0;

            if (STOP) begin
                run_r <= 1'b0;
            end else if (START) begin
                count <= reload_nxt;
                run_r <= 1'b1;
            end else if (count_en) begin
                if (count == '0) begin
                    // Mid-run reload writes only become visible here, at the terminal reload.
                    if (MODE)
                        run_r <= 1'b0;
                    else
                        count <= reload;
                end else begin
                    count <= count - {{(WIDTH-1){1'b0}}, 1'b1};
                end
            end
        end
    end

    assign Q   = count;
    assign TC  = tc_r;
    assign IRQ = irq_r;
    assign RUN = run_r;

endmodule
